// File: rtl/micro_alpha_veryl_mux_arbiter.sv
// micro_alpha_veryl_mux_arbiter
//
// Two-requester round-robin arbiter feeding a single one-word output
// register. The winning requester's word is latched together with its
// index (selector), which drives the ALU operand mux select.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    [1:0]        per-requester valid
//   req_data     [1:0][WIDTH] per-requester payload
//   req_ready    [1:0]        per-requester accept (combinational)
//   out_valid                 output register holds a word
//   out_data     [WIDTH]      held word
//   out_ready                 consumer accepts the held word
//   selector                  index of the requester whose word is held
//   grant_count  [1:0][16]    saturating per-requester transfer counters
module micro_alpha_veryl_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0][WIDTH-1:0] req_data,
  output logic [1:0]            req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  selector,
  output logic [1:0][15:0]      grant_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic [WIDTH-1:0] data_reg;
  logic             sel_reg;

  logic slot_open;
  logic grant;
  logic accept;

  // Next-state, grant and handshake decode.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    req_ready  = 2'b00;
    // A slot opens when the register is empty or is being drained now.
    slot_open  = (state_reg == IDLE) || out_ready;
    // With a single valid requester it wins outright; on contention the
    // round-robin pointer decides.
    grant      = (req_valid == 2'b11) ? ptr_reg : req_valid[1];
    // rst gating keeps req_ready low while reset is held, clock or not.
    accept     = slot_open && (|req_valid) && !rst;

    if (accept) begin
      req_ready[grant] = 1'b1;
      state_next       = HOLD;
      ptr_next         = ~grant;
    end else if ((state_reg == HOLD) && out_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      data_reg  <= '0;
      sel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (accept) begin
        data_reg <= req_data[grant];
        sel_reg  <= grant;
      end
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign out_data  = data_reg;
  assign selector  = sel_reg;

  // Per-requester accepted-transfer counters, saturating at all-ones.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (req_ready[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign grant_count[gi] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_micro_alpha_veryl_mux_arbiter.sv
// Testbench for micro_alpha_veryl_mux_arbiter. Directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_micro_alpha_veryl_mux_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             selector;
  logic [1:0][15:0] grant_count;

  int checks = 0;
  int errors = 0;

  // Reference model: is a word held, what word, from whom, who has
  // priority next, and how many words each requester has delivered.
  bit          m_full;
  logic [31:0] m_data;
  bit          m_sel;
  bit          m_ptr;
  int          m_cnt [2];

  always #5 clk = ~clk;

  micro_alpha_veryl_mux_arbiter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .selector    (selector),
    .grant_count (grant_count)
  );

  task automatic model_reset();
    m_full   = 0;
    m_data   = '0;
    m_sel    = 0;
    m_ptr    = 0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Who would be granted right now, as a one-hot accept vector.
  function automatic logic [1:0] exp_ready();
    bit open;
    bit g;
    if (rst) return 2'b00;
    open = !m_full || out_ready;
    if (!open || req_valid == 2'b00) return 2'b00;
    g = (req_valid == 2'b11) ? m_ptr : req_valid[1];
    return g ? 2'b10 : 2'b01;
  endfunction

  // Apply one clock edge's worth of transactions to the model.
  task automatic model_clock();
    logic [1:0] r;
    bit g;
    r = exp_ready();
    if (r != 2'b00) begin
      g      = r[1];
      m_data = req_data[g];
      m_sel  = g;
      m_full = 1;
      m_ptr  = !g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (out_ready) begin
      m_full = 0;
    end
  endtask

  // Advance one cycle: sample at posedge, return at the next negedge.
  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (selector !== 1'b0) begin errors++; $display("FAIL reset_selector: got %b expected 0", selector); end
    checks++; if (grant_count !== 32'h0) begin errors++; $display("FAIL reset_grant_count: got %h expected 0", grant_count); end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b0;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_single();
    apply_reset();
    req_valid   = 2'b01;
    req_data[0] = 32'hA5A5;
    req_data[1] = 32'hDEAD;
    out_ready   = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'hA5A5) begin errors++; $display("FAIL single_out_data: got %h expected 0000a5a5", out_data); end
    checks++; if (selector !== 1'b0) begin errors++; $display("FAIL single_selector: got %b expected 0", selector); end
    $display("test_single done");
  endtask

  task automatic test_alternate();
    logic [31:0] words [2];
    words[0] = 32'hA5A5;
    words[1] = 32'h5A5A;
    apply_reset();
    req_valid   = 2'b11;
    req_data[0] = words[0];
    req_data[1] = words[1];
    out_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++; if (out_data !== words[i % 2] || selector !== 1'(i % 2) || out_valid !== 1'b1) begin
        errors++; $display("FAIL alternate_word%0d: got data=%h sel=%b valid=%b expected data=%h sel=%0d valid=1", i, out_data, selector, out_valid, words[i % 2], i % 2);
      end
    end
    checks++; if (grant_count[0] !== 16'd2 || grant_count[1] !== 16'd2) begin
      errors++; $display("FAIL alternate_counts: got %0d/%0d expected 2/2", grant_count[0], grant_count[1]);
    end
    $display("test_alternate done");
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid   = 2'b11;
    req_data[0] = 32'hA5A5;
    req_data[1] = 32'h5A5A;
    out_ready   = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_first_ready: got %b expected 01", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      req_data[0] = $urandom;
      req_data[1] = $urandom;
      #1;
      checks++; if (req_ready !== 2'b00 || out_data !== 32'hA5A5 || selector !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got ready=%b data=%h sel=%b valid=%b expected ready=00 data=0000a5a5 sel=0 valid=1", i, req_ready, out_data, selector, out_valid);
      end
      tick();
    end
    req_data[1] = 32'h5A5A;
    out_ready   = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release_ready: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (out_data !== 32'h5A5A || selector !== 1'b1) begin
      errors++; $display("FAIL stall_next_word: got data=%h sel=%b expected 00005a5a/1", out_data, selector);
    end
    $display("test_stall done");
  endtask

  task automatic test_req1_only();
    apply_reset();
    req_valid   = 2'b10;
    req_data[0] = 32'h1111;
    req_data[1] = 32'h5A5A;
    out_ready   = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL req1_ready: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b11;
    #1;
    checks++; if (selector !== 1'b1 || out_data !== 32'h5A5A) begin
      errors++; $display("FAIL req1_output: got sel=%b data=%h expected 1/00005a5a", selector, out_data);
    end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL req1_pointer_back: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (selector !== 1'b0 || out_data !== 32'h1111) begin
      errors++; $display("FAIL req1_then0: got sel=%b data=%h expected 0/00001111", selector, out_data);
    end
    $display("test_req1_only done");
  endtask

  task automatic test_random();
    logic [1:0] er;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid   = 2'($urandom_range(0, 3));
      req_data[0] = $urandom;
      req_data[1] = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      checks++; if (req_ready !== er) begin errors++; $display("FAIL random_ready cyc%0d: got %b expected %b", i, req_ready, er); end
      checks++; if (out_valid !== m_full || out_data !== m_data || selector !== m_sel) begin
        errors++; $display("FAIL random_output cyc%0d: got valid=%b data=%h sel=%b expected valid=%b data=%h sel=%b", i, out_valid, out_data, selector, m_full, m_data, m_sel);
      end
      checks++; if (grant_count[0] !== 16'(m_cnt[0]) || grant_count[1] !== 16'(m_cnt[1])) begin
        errors++; $display("FAIL random_counts cyc%0d: got %0d/%0d expected %0d/%0d", i, grant_count[0], grant_count[1], m_cnt[0], m_cnt[1]);
      end
      tick();
    end
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid   = 2'b10;
    req_data[1] = 32'h5A5A;
    out_ready   = 1'b1;
    tick();
    req_valid = 2'b11;
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A5A) begin
      errors++; $display("FAIL async_setup: got valid=%b data=%h expected 1/00005a5a", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || selector !== 1'b0) begin
      errors++; $display("FAIL async_clear: got valid=%b data=%h sel=%b expected 0/0/0", out_valid, out_data, selector);
    end
    checks++; if (grant_count !== 32'h0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL async_counts: got cnt=%h ready=%b expected 0/00", grant_count, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst         = 1'b0;
    req_valid   = 2'b11;
    req_data[0] = 32'hA5A5;
    out_ready   = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL async_first_grant: got %b expected 01", req_ready); end
    tick();
    #1;
    checks++; if (out_data !== 32'hA5A5 || selector !== 1'b0) begin
      errors++; $display("FAIL async_first_word: got data=%h sel=%b expected 0000a5a5/0", out_data, selector);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_saturate();
    apply_reset();
    req_valid   = 2'b01;
    req_data[0] = 32'h7;
    out_ready   = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    #1;
    checks++; if (grant_count[0] !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h expected fffe", grant_count[0]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (grant_count[0] !== 16'hFFFF || grant_count[0] !== 16'(m_cnt[0])) begin
        errors++; $display("FAIL sat_step%0d: got %h expected ffff", i, grant_count[0]);
      end
    end
    $display("test_saturate done");
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_req1_only();
    test_random();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_alpha_veryl_mux_arbiter.md
MICRO_ALPHA_VERYL_MUX_ARBITER -- requirements
Module: micro_alpha_veryl_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each requester and of the output SHALL be WIDTH bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 req_valid  input  2  per-requester valid; bit i belongs to requester i.
REQ-005 req_data  input  2 x WIDTH  per-requester payload; req_data[i] belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; transfer on requester i when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-007 out_valid  output  1  held output word is valid.
REQ-008 out_data  output  WIDTH  held output word.
REQ-009 out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both 1 at a clock edge.
REQ-010 selector  output  1  index of the requester whose word is in out_data; drives the ALU operand mux select.
REQ-011 grant_count  output  2 x 16  per-requester accepted-transfer counters.

Function
REQ-012 The block SHALL contain two states, IDLE (output register empty) and HOLD (output register full).
REQ-013 A slot SHALL be open when state is IDLE, or when state is HOLD and out_ready is 1.
REQ-014 When a slot is open and at least one req_valid bit is 1, exactly one req_ready bit SHALL be 1 combinationally in that cycle, for the granted requester; otherwise req_ready SHALL be 2'b00.
REQ-015 Grant rule: if only one requester is valid, it SHALL be granted; if both are valid, the requester indicated by the priority pointer SHALL be granted.
REQ-016 After each accepted transfer from requester i, the priority pointer SHALL point to requester 1-i (round-robin). Without a transfer it SHALL hold.
REQ-017 On an accepted request, req_data[grant] SHALL be captured into out_data, grant into selector, and out_valid SHALL be 1 from the next cycle. Request-to-output latency SHALL be 1 cycle.
REQ-018 IDLE -> HOLD on an accepted request. HOLD -> IDLE when out_ready=1 and no request is accepted. HOLD -> HOLD when out_ready=0, or when out_ready=1 and a request is accepted in the same cycle, giving back-to-back throughput of one word per cycle.
REQ-019 While HOLD and out_ready=0, out_data, selector and out_valid SHALL remain stable, and req_ready SHALL be 2'b00.
REQ-020 out_valid SHALL be 0 in IDLE. out_data and selector SHALL keep their last value in IDLE.
REQ-021 grant_count[i] SHALL increment by 1 on each accepted transfer from requester i and SHALL saturate at 16'hFFFF (no wrap).
REQ-022 A requester whose req_valid stays 1 SHALL be granted within 2 open slots (no starvation).
REQ-023 The block SHALL ignore req_data of a requester that is not granted. Requesters MAY drop req_valid without a transfer.

Reset
REQ-024 While rst=1, with no clock required: state SHALL be IDLE, out_valid=0, out_data=0, selector=0, priority pointer=requester 0, grant_count={0,0}, req_ready=2'b00.
REQ-025 Assertion of rst in HOLD SHALL discard the held word. The first grant after rst deasserts SHALL follow REQ-015 with pointer=0.

Verification
REQ-026 Reset, then req_valid=2'b01, req_data[0]=32'hA5A5 -> req_ready=2'b01 same cycle; next cycle out_valid=1, out_data=32'hA5A5, selector=0.
REQ-027 Both valid continuously, req_data[0]=32'hA5A5, req_data[1]=32'h5A5A, out_ready=1 -> outputs alternate A5A5, 5A5A, A5A5 on consecutive cycles with selector 0,1,0; counters both increment.
REQ-028 HOLD with out_ready=0 for 5 cycles, both requesters valid -> req_ready=2'b00, out_data and selector unchanged; on out_ready=1, next word is granted in the same cycle.
REQ-029 Only requester 1 valid with the pointer at 0 -> requester 1 is granted and selector=1; the pointer then moves to 0.
REQ-030 grant_count[0] preloaded to 16'hFFFE through 3 accepted transfers -> reads 16'hFFFF and stays there.
REQ-031 rst asserted asynchronously mid-HOLD with out_data=32'h5A5A -> out_valid drops to 0 immediately, out_data=0, counters=0; after release, simultaneous requests grant requester 0 first.
